// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3 peripheral constants and the data-phase owner encoding
// used by the slave mux and its built-in default slave.
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Wide enough to index up to 16 slaves.
    localparam int unsigned DSEL_IDX_W = 4;

    typedef enum logic [1:0] {
        DSEL_NONE,
        DSEL_SLV,
        DSEL_DEF
    } dsel_kind_e;

    typedef struct packed {
        dsel_kind_e              kind;
        logic [DSEL_IDX_W-1:0]   idx;
    } dsel_t;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_e;

    function automatic logic is_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/peripheral_ahb3_default_slave.sv
// Built-in default slave: answers unmapped NONSEQ/SEQ transfers with the
// two-cycle AHB ERROR response and flags each one on decode_err.
module peripheral_ahb3_default_slave
    import peripheral_ahb3_pkg::*;
(
    input  logic       HRESETn,
    input  logic       HCLK,
    input  logic       HSEL,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic       HREADYOUT,
    output logic       HRESP,
    output logic       decode_err
);

    ds_state_e state;
    ds_state_e state_next;
    logic      accept;

    assign accept = HSEL & HREADY & is_active(HTRANS);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= DS_IDLE;
            decode_err <= 1'b0;
        end else begin
            state      <= state_next;
            decode_err <= accept && (state != DS_ERR1);
        end
    end

    always_comb begin
        state_next = state;
        HREADYOUT  = 1'b1;
        HRESP      = HRESP_OKAY;
        case (state)
            DS_IDLE: begin
                if (accept) state_next = DS_ERR1;
            end
            DS_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = HRESP_ERROR;
                state_next = DS_ERR2;
            end
            DS_ERR2: begin
                HRESP      = HRESP_ERROR;
                state_next = accept ? DS_ERR1 : DS_IDLE;
            end
            default: state_next = DS_IDLE;
        endcase
    end

endmodule

// File: rtl/peripheral_ahb3_slave_mux.sv
// AHB-Lite address decoder and response mux with a default slave for
// unmapped addresses. HREADY is shared by the master and every slave.
module peripheral_ahb3_slave_mux
    import peripheral_ahb3_pkg::*;
#(
    parameter int unsigned SLAVES     = 4,
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32,
    parameter logic [SLAVES*HADDR_SIZE-1:0] SLV_BASE =
        {32'h4000_3000, 32'h4000_2000, 32'h4000_1000, 32'h4000_0000},
    parameter logic [SLAVES*HADDR_SIZE-1:0] SLV_MASK = {4{32'hFFFF_F000}}
) (
    input  logic                         HRESETn,
    input  logic                         HCLK,
    input  logic                         HSEL,
    input  logic [HADDR_SIZE-1:0]        HADDR,
    input  logic [1:0]                   HTRANS,
    output logic [SLAVES-1:0]            HSEL_S,
    input  logic [SLAVES*HDATA_SIZE-1:0] HRDATA_S,
    input  logic [SLAVES-1:0]            HREADYOUT_S,
    input  logic [SLAVES-1:0]            HRESP_S,
    output logic [HDATA_SIZE-1:0]        HRDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic                         decode_err
);

    logic [SLAVES-1:0]     hit;
    logic                  hit_any;
    logic [DSEL_IDX_W-1:0] hit_idx;
    logic                  miss;
    dsel_t                 dsel;
    logic                  def_ready;
    logic                  def_resp;

    // Lowest matching index wins so overlapping windows still give one-hot.
    always_comb begin
        hit     = '0;
        hit_any = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < SLAVES; i++) begin
            if (HSEL && !hit_any &&
                ((HADDR & SLV_MASK[i*HADDR_SIZE +: HADDR_SIZE]) ==
                 SLV_BASE[i*HADDR_SIZE +: HADDR_SIZE])) begin
                hit[i]  = 1'b1;
                hit_any = 1'b1;
                hit_idx = DSEL_IDX_W'(i);
            end
        end
    end

    assign HSEL_S = hit;
    assign miss   = HSEL & ~hit_any;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= '{kind: DSEL_NONE, idx: '0};
        end else if (HREADY) begin
            if (hit_any)   dsel <= '{kind: DSEL_SLV,  idx: hit_idx};
            else if (miss) dsel <= '{kind: DSEL_DEF,  idx: '0};
            else           dsel <= '{kind: DSEL_NONE, idx: '0};
        end
    end

    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        case (dsel.kind)
            DSEL_SLV: begin
                for (int unsigned i = 0; i < SLAVES; i++) begin
                    if (dsel.idx == DSEL_IDX_W'(i)) begin
                        HRDATA = HRDATA_S[i*HDATA_SIZE +: HDATA_SIZE];
                        HREADY = HREADYOUT_S[i];
                        HRESP  = HRESP_S[i];
                    end
                end
            end
            DSEL_DEF: begin
                HREADY = def_ready;
                HRESP  = def_resp;
            end
            default: ;
        endcase
    end

    peripheral_ahb3_default_slave u_default_slave (
        .HRESETn    (HRESETn),
        .HCLK       (HCLK),
        .HSEL       (miss),
        .HTRANS     (HTRANS),
        .HREADY     (HREADY),
        .HREADYOUT  (def_ready),
        .HRESP      (def_resp),
        .decode_err (decode_err)
    );

endmodule

// File: doc/peripheral_ahb3_slave_mux.md
Name: peripheral_ahb3_slave_mux

Overview:
AHB-Lite address decoder and response multiplexer that sits directly upstream of the AHB-to-APB bridges and other AHB3 peripheral slaves.
- Decodes each address-phase HADDR into one HSEL per slave.
- Tracks the data-phase owner and returns that slave's HRDATA/HREADYOUT/HRESP to the master, plus the shared HREADY to all slaves.
- Contains a built-in default slave that gives the two-cycle ERROR response for unmapped accesses.

Parameters:
- SLAVES, 4, number of attached slaves (1..16).
- HADDR_SIZE, 32, address width.
- HDATA_SIZE, 32, data width.
- SLV_BASE, {32'h4000_3000,32'h4000_2000,32'h4000_1000,32'h4000_0000}, packed SLAVES*HADDR_SIZE base addresses, slave 0 in LSBs.
- SLV_MASK, {4{32'hFFFF_F000}}, packed SLAVES*HADDR_SIZE decode masks.

Ports:
- HRESETn  in  1  asynchronous, active-low reset.
- HCLK  in  1  clock; all logic on rising edge.
- HSEL  in  1  region select from upstream.
- HADDR  in  HADDR_SIZE  master address.
- HTRANS  in  2  master transfer type.
- HSEL_S  out  SLAVES  per-slave select (combinational).
- HRDATA_S  in  SLAVES*HDATA_SIZE  slave read data.
- HREADYOUT_S  in  SLAVES  slave ready.
- HRESP_S  in  SLAVES  slave response.
- HRDATA  out  HDATA_SIZE  muxed read data to master.
- HREADY  out  1  muxed ready to master and to every slave's HREADY input.
- HRESP  out  1  muxed response to master.
- decode_err  out  1  one-cycle pulse per accepted unmapped transfer.

Behaviour:
- Decode (combinational): hit[i] = HSEL & ((HADDR & SLV_MASK[i]) == SLV_BASE[i]).
  - Overlapping hits: lowest index wins; result is one-hot.
  - HSEL_S = that one-hot vector. It is driven even when HTRANS is IDLE; slaves qualify with HTRANS themselves.
  - miss = HSEL & ~|hit.
- Data-phase select register dsel. Encodings: NONE, SLV[i], DEF.
  - Updates only when HREADY=1.
  - Loads SLV[i] on hit[i]; DEF on miss; NONE when HSEL=0.
  - Holds its value while HREADY=0.
- Output mux:
  - NONE: HRDATA=0, HREADY=1, HRESP=OKAY.
  - SLV[i]: slice i of HRDATA_S/HREADYOUT_S/HRESP_S.
  - DEF: HRDATA=0, HREADY/HRESP from the default-slave FSM.
- Default-slave FSM states: DS_IDLE, DS_ERR1, DS_ERR2.
  - DS_IDLE: outputs ready=1, OKAY. If miss & HREADY=1 & HTRANS in {NONSEQ,SEQ} -> DS_ERR1 and pulse decode_err. IDLE/BUSY misses stay in DS_IDLE (zero-wait OKAY).
  - DS_ERR1: outputs ready=0, ERROR; next state DS_ERR2 unconditionally.
  - DS_ERR2: outputs ready=1, ERROR. If another unmapped NONSEQ/SEQ is accepted this cycle -> DS_ERR1 (back-to-back errors) and pulse decode_err; else -> DS_IDLE.
- Latency: decode adds 0 cycles. Mapped slave wait states pass through unchanged. Unmapped access costs exactly 2 data-phase cycles.
- Reset values (registered state):
  - dsel=NONE, FSM=DS_IDLE, decode_err=0.
  - Hence HREADY=1, HRESP=OKAY, HRDATA=0 while HRESETn=0.
- Reset mid-transfer: dsel and FSM clear immediately (asynchronous). The master sees HREADY=1/OKAY on the next cycle, with no spurious error.
- HREADY is combinational from slave HREADYOUT. Slaves must register HREADYOUT, so no combinational loop exists through this block.

Decomposition:
- peripheral_ahb3_pkg supplies HTRANS_* and HRESP_* constants (existing). Add a dsel encoding typedef there.
- One natural sub-module, peripheral_ahb3_default_slave: holds the FSM and the decode_err pulse, with inputs HSEL (=miss), HTRANS, HREADY and outputs HREADYOUT, HRESP.
- Decode and mux stay in the top module.

Test Plan:
- Reset: hold HRESETn=0 with arbitrary slave inputs -> HREADY=1, HRESP=0, HRDATA=0, decode_err=0.
- NONSEQ read at 0x4000_2004 -> HSEL_S=4'b0100 in the address phase. In the data phase HRDATA=HRDATA_S slice 2 (0xCAFE_0002); HREADY follows HREADYOUT_S[2] through 3 wait cycles.
- NONSEQ at unmapped 0x5000_0000 -> HSEL_S=0, decode_err=1 for 1 cycle. Data phase: cycle1 HREADY=0/HRESP=1, cycle2 HREADY=1/HRESP=1, then OKAY.
- Back-to-back unmapped NONSEQs (second issued in the ERR2 cycle) -> FSM goes ERR2->ERR1 and two decode_err pulses appear. IDLE at an unmapped address -> zero-wait OKAY with no pulse.
- Pipelined write to slave 0 then read from slave 1 while slave 0 stretches 2 waits -> dsel stays SLV[0] until HREADY=1, then switches to SLV[1]. HSEL_S=4'b0010 is held through the stall.
- Assert HRESETn=0 during DS_ERR1 -> next cycle HREADY=1, HRESP=OKAY; FSM returns to DS_IDLE after release.
